rom_read_and_d_loader: RTL and testbench
========================================

Name: rom_read_and_D_loader

Overview:
- Writer side of the read-and-D store used by the search engine.
- Accepts a stream of short-read symbols and their search-bound values D(i) over a valid/ready handshake.
- Packs each pair into a 10-bit word in an internal RAM and serves the same asynchronous read port the search core already uses (ce, addr, d_i, read_i).
- Replaces file-loaded contents so each short read is loaded at run time.

Parameters:
- DEPTH, 255, usable entries (addresses 0..DEPTH-1); 8'hff is reserved as index -1 and is never written.
- D_W, 8, width of D(i).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse: clear length and error state, enter LOAD.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  loader can accept a word.
- in_base  in  2  symbol: 00 A, 01 C, 10 G, 11 T.
- in_d  in  D_W  D(i) for this symbol.
- in_last  in  1  marks the final symbol of the read.
- ce  in  1  read enable (search side).
- addr  in  8  read index; 8'hff means -1.
- d_i  out  D_W  D(addr), combinational.
- read_i  out  2  symbol at addr, combinational.
- read_len  out  8  number of stored entries.
- load_done  out  1  high in DONE.
- overflow  out  1  sticky: a write was attempted past DEPTH.

Behaviour:
- Reset (async, rst=1): state IDLE, read_len=0, load_done=0, overflow=0, in_ready=0. RAM contents are not cleared.
- FSM IDLE -> LOAD on start.
- LOAD -> DONE on an accepted word with in_last=1, or on overflow.
- DONE -> LOAD on start. DONE holds otherwise.
- start in any state: next cycle read_len=0, overflow=0, load_done=0, state LOAD. A start during LOAD aborts that load; a word offered in the same cycle as start is dropped.
- in_ready = (state==LOAD) && (read_len < DEPTH). It is a registered-state function with no combinational dependence on in_valid.
- Accept = in_valid && in_ready. On accept: mem[read_len] <= {in_base, in_d}; read_len increments by 1 on the same edge.
- A written entry is readable the cycle after the accepting edge.
- Overflow: in LOAD with read_len==DEPTH and in_valid=1, set overflow=1, go to DONE, write nothing.
- Read port is combinational:
  - ce=0 -> d_i=0, read_i=0.
  - addr==8'hff -> d_i=0, read_i=0.
  - addr >= read_len -> d_i=0, read_i=0.
  - otherwise the mem word at addr.
- Reads are legal in any state, including concurrently with writes to a different address. A read of the address being written in the same cycle returns 0, since read_len has not yet advanced.
- read_len saturates at DEPTH and never wraps.
- Reset mid-load returns to IDLE with read_len=0. Stale RAM is masked by the addr >= read_len rule.

Optional Feature:
- Macro READ_AND_D_CHECK_EN.
- When defined:
  - Adds output d_err (1-bit, sticky, reset 0, cleared by start).
  - For each accepted word with index > 0: if in_d < previous D or in_d > previous D + 1, set d_err. D must be non-decreasing with step 0 or 1.
  - A first word with in_d > 1 also sets d_err.
  - Previous D is held in a D_W register, reset 0.
  - The word is still written.
- When undefined: no d_err port and no comparator logic.

Decomposition:
- Shared package rom_read_and_D_pkg:
  - Base encodings BASE_A..BASE_T.
  - ADDR_NEG1 = 8'hff.
  - Entry word width 10 and field slices [9:8] symbol, [7:0] D.
  - FSM state typedef {IDLE, LOAD, DONE}.
- One natural sub-module: rom_read_and_D_ram, the DEPTH x 10 RAM with a synchronous write port and an asynchronous read port. The top holds the FSM, counter, handshake and masking.

Test Plan:
- Reset then read: rst pulse, ce=1, addr=0 -> d_i=0, read_i=0, read_len=0, in_ready=0.
- Basic load: start; stream 4 words (G,0),(A,0),(T,1),(C,1) with in_valid held high, last on the 4th -> in_ready high 4 cycles, read_len=4, load_done=1; addr=2 gives read_i=2'b11, d_i=1; addr=4 gives 0; addr=8'hff gives 0.
- Backpressure/gaps: toggle in_valid randomly over 10 words -> exactly 10 writes in order, read_len=10, no duplicates.
- Overflow: stream 256 words, last never set -> 255 stored, overflow=1, load_done=1, in_ready=0, read_len=255.
- Restart mid-load: after 3 accepted words, pulse start with in_valid=1 -> that word is dropped, read_len=0; a new 2-word load gives read_len=2, and addr=2 reads 0.
- With READ_AND_D_CHECK_EN: D sequence 0,1,1,3 -> d_err rises after the 4th accept. Sequence 0,0,1,2 keeps d_err=0. start clears d_err.

Source files
------------

// File: rtl/rom_read_and_d_loader_pkg.sv
// rom_read_and_D_pkg
// Shared definitions for the read-and-D store: symbol encodings, the
// reserved "-1" read index, entry layout and the loader FSM states.
// Entry layout: [SYM_W+D_W-1 -: SYM_W] symbol, [D_W-1:0] D(i); 10 bits with
// the default 8-bit D.
package rom_read_and_D_pkg;

  localparam int unsigned SYM_W   = 2;
  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  localparam logic [7:0] ADDR_NEG1 = 8'hff;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/rom_read_and_d_loader_ram.sv
// rom_read_and_D_ram
// DEPTH x W storage for packed {symbol, D} entries. Synchronous write,
// asynchronous read. Contents are never reset.
// Ports:
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write index
//   wdata_i  in   entry to store
//   raddr_i  in   read index (indices >= DEPTH read as zero)
//   rdata_o  out  entry at raddr_i, combinational
module rom_read_and_D_ram
  import rom_read_and_D_pkg::*;
#(
  parameter int unsigned DEPTH = 255,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [7:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [7:0]   raddr_i,
  output logic [W-1:0] rdata_o
);

  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_L)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i < DEPTH_L) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/rom_read_and_d_loader.sv
// rom_read_and_d_loader
// Run-time loader for the read-and-D store. Accepts {symbol, D(i)} pairs over
// valid/ready, packs them into RAM and serves the search core's combinational
// read port with masking of index -1 and unwritten entries.
// Optional: define READ_AND_D_CHECK_EN to add the sticky d_err monotonic
// step checker on incoming D values.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse: clear length/errors, enter LOAD
//   in_valid/in_ready upstream handshake
//   in_base, in_d     symbol and D(i); in_last marks the final symbol
//   ce, addr          search-side read enable and index (8'hff = -1)
//   d_i, read_i       D and symbol at addr (zero when masked)
//   read_len          number of stored entries
//   load_done         high in DONE
//   overflow          sticky: write attempted past DEPTH
//   d_err             (READ_AND_D_CHECK_EN only) sticky D sequence error
module rom_read_and_d_loader
  import rom_read_and_D_pkg::*;
#(
  parameter int unsigned DEPTH = 255,
  parameter int unsigned D_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_base,
  input  logic [D_W-1:0] in_d,
  input  logic           in_last,
  input  logic           ce,
  input  logic [7:0]     addr,
  output logic [D_W-1:0] d_i,
  output logic [1:0]     read_i,
  output logic [7:0]     read_len,
  output logic           load_done,
  output logic           overflow
`ifdef READ_AND_D_CHECK_EN
  ,
  output logic           d_err
`endif
);

  localparam int unsigned W       = SYM_W + D_W;
  localparam logic [7:0]  DEPTH_L = 8'(DEPTH);

  state_e       state_q, state_d;
  logic [7:0]   len_q, len_d;
  logic         ovf_q, ovf_d;
  logic         accept, wr_en, hit;
  logic [W-1:0] rd_word;

  assign in_ready = (state_q == LOAD) && (len_q < DEPTH_L);
  assign accept   = in_valid && in_ready;
  // start wins over a word offered in the same cycle: that word is dropped.
  assign wr_en    = accept && !start;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = LOAD;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (accept) begin
            len_d = len_q + 8'd1;
            if (in_last) state_d = DONE;
          end else if (in_valid && (len_q == DEPTH_L)) begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  rom_read_and_D_ram #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (len_q),
    .wdata_i ({in_base, in_d}),
    .raddr_i (addr),
    .rdata_o (rd_word)
  );

  // len_q only advances on the write edge, so a same-cycle read of the
  // address being written is masked, as is any stale RAM after reset.
  assign hit    = ce && (addr != ADDR_NEG1) && (addr < len_q);
  assign d_i    = hit ? rd_word[D_W-1:0] : '0;
  assign read_i = hit ? rd_word[D_W +: SYM_W] : '0;

  assign read_len  = len_q;
  assign load_done = (state_q == DONE);
  assign overflow  = ovf_q;

`ifdef READ_AND_D_CHECK_EN
  logic [D_W-1:0] prev_d_q;
  logic           derr_q, derr_d;
  logic [D_W:0]   prev_p1;

  // Widened by one bit so prev+1 cannot wrap at the top of the D range.
  assign prev_p1 = {1'b0, prev_d_q} + (D_W+1)'(1);

  always_comb begin
    derr_d = derr_q;
    if (start) begin
      derr_d = 1'b0;
    end else if (wr_en) begin
      if (len_q == '0) begin
        if (in_d > D_W'(1)) derr_d = 1'b1;
      end else if ((in_d < prev_d_q) || ({1'b0, in_d} > prev_p1)) begin
        derr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_d_q <= '0;
      derr_q   <= 1'b0;
    end else begin
      derr_q <= derr_d;
      if (wr_en) prev_d_q <= in_d;
    end
  end

  assign d_err = derr_q;
`endif

endmodule

// File: tb/tb_rom_read_and_d_loader.sv
module tb_rom_read_and_d_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_base = '0;
  logic [7:0] in_d = '0;
  logic       in_last = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] addr = '0;
  logic [7:0] d_i;
  logic [1:0] read_i;
  logic [7:0] read_len;
  logic       load_done;
  logic       overflow;
`ifdef READ_AND_D_CHECK_EN
  logic       d_err;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  rom_read_and_d_loader #(
    .DEPTH (255),
    .D_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_d      (in_d),
    .in_last   (in_last),
    .ce        (ce),
    .addr      (addr),
    .d_i       (d_i),
    .read_i    (read_i),
    .read_len  (read_len),
    .load_done (load_done),
    .overflow  (overflow)
`ifdef READ_AND_D_CHECK_EN
    ,
    .d_err     (d_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer one word at a negedge and hold it until an edge accepts it.
  task automatic send(input logic [1:0] b, input logic [7:0] d, input logic last);
    logic took;
    took = 1'b0;
    @(negedge clk);
    in_base  = b;
    in_d     = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int unsigned n = 0; n < 20 && !took; n++) begin
      if (in_ready) begin
        took = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accepted", {31'b0, took}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [1:0] eb, input logic [7:0] ed);
    addr = a;
    #1;
    check({tag, "_sym"}, {30'b0, read_i}, {30'b0, eb});
    check({tag, "_d"}, {24'b0, d_i}, {24'b0, ed});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bb;
    logic [7:0] dd;

    // Reset, read while held
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rd("rst_rd0", 8'd0, 2'd0, 8'd0);
    check("rst_len", {24'b0, read_len}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic 4-word load: (G,0) (A,0) (T,1) (C,1)
    pulse_start();
    check("ld_ready", {31'b0, in_ready}, 32'd1);
    send(2'b10, 8'd0, 1'b0);
    send(2'b00, 8'd0, 1'b0);
    send(2'b11, 8'd1, 1'b0);
    send(2'b01, 8'd1, 1'b1);
    check("ld_len", {24'b0, read_len}, 32'd4);
    check("ld_done", {31'b0, load_done}, 32'd1);
    check("ld_ready_off", {31'b0, in_ready}, 32'd0);
    rd("ld_a0", 8'd0, 2'b10, 8'd0);
    rd("ld_a2", 8'd2, 2'b11, 8'd1);
    rd("ld_a3", 8'd3, 2'b01, 8'd1);
    rd("ld_a4", 8'd4, 2'b00, 8'd0);
    rd("ld_neg1", 8'hff, 2'b00, 8'd0);
    ce = 1'b0;
    rd("ld_ce0", 8'd2, 2'b00, 8'd0);
    ce = 1'b1;

    // Ten words with random idle gaps; word 5 probes same-cycle masking
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bb = 2'(i);
      dd = 8'(i * 3 + 5);
      if (i == 5) begin
        @(negedge clk);
        addr = 8'd5; in_base = bb; in_d = dd; in_last = 1'b0; in_valid = 1'b1;
        #1;
        check("same_cyc", {22'b0, read_i, d_i}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("next_cyc", {22'b0, read_i, d_i}, {22'b0, 2'b01, 8'd20});
      end else begin
        send(bb, dd, (i == 9));
      end
    end
    check("bp_len", {24'b0, read_len}, 32'd10);
    check("bp_done", {31'b0, load_done}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      rd("bp_rd", 8'(i), 2'(i), 8'(i * 3 + 5));
    end
    rd("bp_a10", 8'd10, 2'b00, 8'd0);

    // Overflow: 256 words, last never set
    pulse_start();
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_base = 2'(i);
      in_d    = 8'(i);
      @(posedge clk);
      #1;
      if (i == 254) begin
        check("ov_full_len", {24'b0, read_len}, 32'd255);
        check("ov_full_rdy", {31'b0, in_ready}, 32'd0);
        check("ov_not_yet", {31'b0, overflow}, 32'd0);
      end
    end
    in_valid = 1'b0;
    check("ov_flag", {31'b0, overflow}, 32'd1);
    check("ov_done", {31'b0, load_done}, 32'd1);
    check("ov_len", {24'b0, read_len}, 32'd255);
    check("ov_ready", {31'b0, in_ready}, 32'd0);
    rd("ov_a254", 8'd254, 2'b10, 8'hfe);
    rd("ov_a7", 8'd7, 2'b11, 8'd7);
    rd("ov_neg1", 8'hff, 2'b00, 8'd0);

    // Restart mid-load; word offered with start is dropped
    pulse_start();
    check("rs_ovf_clr", {31'b0, overflow}, 32'd0);
    send(2'b01, 8'd1, 1'b0);
    send(2'b01, 8'd2, 1'b0);
    send(2'b01, 8'd3, 1'b0);
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_base = 2'b01; in_d = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
    check("rs_len0", {24'b0, read_len}, 32'd0);
    check("rs_done0", {31'b0, load_done}, 32'd0);
    rd("rs_a0_mask", 8'd0, 2'b00, 8'd0);
    send(2'b11, 8'd7, 1'b0);
    send(2'b00, 8'd8, 1'b1);
    check("rs_len2", {24'b0, read_len}, 32'd2);
    rd("rs_a0", 8'd0, 2'b11, 8'd7);
    rd("rs_a1", 8'd1, 2'b00, 8'd8);
    rd("rs_a2", 8'd2, 2'b00, 8'd0);

    // Reset mid-load
    pulse_start();
    send(2'b10, 8'd4, 1'b0);
    send(2'b10, 8'd5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_len", {24'b0, read_len}, 32'd0);
    check("mr_ready", {31'b0, in_ready}, 32'd0);
    rd("mr_a0", 8'd0, 2'b00, 8'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef READ_AND_D_CHECK_EN
    pulse_start();
    send(2'b00, 8'd0, 1'b0);
    send(2'b00, 8'd1, 1'b0);
    send(2'b00, 8'd1, 1'b0);
    check("de_ok3", {31'b0, d_err}, 32'd0);
    send(2'b00, 8'd3, 1'b1);
    check("de_jump", {31'b0, d_err}, 32'd1);
    check("de_written", {24'b0, read_len}, 32'd4);
    pulse_start();
    check("de_clr", {31'b0, d_err}, 32'd0);
    send(2'b00, 8'd0, 1'b0);
    send(2'b00, 8'd0, 1'b0);
    send(2'b00, 8'd1, 1'b0);
    send(2'b00, 8'd2, 1'b1);
    check("de_good", {31'b0, d_err}, 32'd0);
    pulse_start();
    send(2'b00, 8'd2, 1'b1);
    check("de_first", {31'b0, d_err}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
